// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle instruction sequencer for the CPU datapath.
// Walks each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB and turns the
// decode flags into per-cycle enables. It handshakes with variable-latency
// instruction and data memories. A watchdog moves to a sticky ERROR state
// when a memory never acknowledges.
// Optional feature macro: MC_SEQ_PERF_CNT_EN adds the cycle_cnt and
// instret_cnt performance counters.
module mc_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        RegWr,
  input  logic        MemWr,
  input  logic        MemToReg,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        Link,
  input  logic        br_taken,
  output logic        imem_req,
  input  logic        imem_ack,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ack,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        reg_we,
  output logic        retire,
  output logic [2:0]  state,
  output logic        err
`ifdef MC_SEQ_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERROR  = 3'd7
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  state_e             next_s;
  logic               timeout_s;
  logic               imem_req_s, dmem_req_s, dmem_we_s, ir_we_s;
  logic               pc_we_s, reg_we_s, retire_s, err_s;
  logic [1:0]         pc_sel_s;

  // State register and wait counter; reset overrides any pending ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, watchdog counter and per-cycle enable decode.
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    imem_req_s = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    ir_we_s    = 1'b0;
    pc_we_s    = 1'b0;
    pc_sel_s   = 2'd0;
    reg_we_s   = 1'b0;
    retire_s   = 1'b0;
    err_s      = 1'b0;
    next_s     = run ? S_FETCH : S_IDLE;
    timeout_s  = (cnt_q == CNT_W'(ACK_TIMEOUT));
    case (state_q)
      S_IDLE: begin
        state_d = run ? S_FETCH : S_IDLE;
      end
      S_FETCH: begin
        imem_req_s = 1'b1;
        if (imem_ack) begin
          ir_we_s = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DECODE: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (Jump && Link) begin
          // PC update waits for WB so the link value still sees old PC+4.
          state_d = S_WB;
        end else if (Jump) begin
          pc_we_s  = 1'b1;
          pc_sel_s = 2'd2;
          retire_s = 1'b1;
          state_d  = next_s;
        end else if (Branch) begin
          pc_we_s  = 1'b1;
          pc_sel_s = br_taken ? 2'd1 : 2'd0;
          retire_s = 1'b1;
          state_d  = next_s;
        end else if (MemToReg || MemWr) begin
          state_d = S_MEM;
        end else if (RegWr) begin
          state_d = S_WB;
        end else begin
          pc_we_s  = 1'b1;
          retire_s = 1'b1;
          state_d  = next_s;
        end
      end
      S_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = MemWr;
        if (dmem_ack) begin
          if (MemToReg) begin
            state_d = S_WB;
          end else begin
            pc_we_s  = 1'b1;
            retire_s = 1'b1;
            state_d  = next_s;
          end
        end else if (timeout_s) begin
          state_d = S_ERROR;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB: begin
        reg_we_s = 1'b1;
        pc_we_s  = 1'b1;
        retire_s = 1'b1;
        pc_sel_s = (Jump && Link) ? 2'd2 : 2'd0;
        state_d  = next_s;
      end
      S_ERROR: begin
        err_s   = 1'b1;
        state_d = S_ERROR;
      end
      default: begin
        // Unused encoding: treat as a fault.
        state_d = S_ERROR;
      end
    endcase
  end

  // Outputs are forced low while reset is asserted.
  assign imem_req = imem_req_s & ~rst;
  assign dmem_req = dmem_req_s & ~rst;
  assign dmem_we  = dmem_we_s  & ~rst;
  assign ir_we    = ir_we_s    & ~rst;
  assign pc_we    = pc_we_s    & ~rst;
  assign pc_sel   = rst ? 2'd0 : pc_sel_s;
  assign reg_we   = reg_we_s   & ~rst;
  assign retire   = retire_s   & ~rst;
  assign err      = err_s      & ~rst;
  assign state    = rst ? 3'd0 : state_q;

`ifdef MC_SEQ_PERF_CNT_EN
  logic [31:0] cycle_q, instret_q;

  // Active-cycle and retired-instruction counters; both wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q   <= 32'd0;
      instret_q <= 32'd0;
    end else begin
      cycle_q   <= ((state_q != S_IDLE) && (state_q != S_ERROR)) ? cycle_q + 32'd1 : cycle_q;
      instret_q <= retire_s ? instret_q + 32'd1 : instret_q;
    end
  end

  assign cycle_cnt   = rst ? 32'd0 : cycle_q;
  assign instret_cnt = rst ? 32'd0 : instret_q;
`endif

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed testbench for mc_sequencer (ACK_TIMEOUT = 4).
// Each cycle the outputs are packed as
// {state[2:0], imem_req, dmem_req, dmem_we, ir_we, pc_we, pc_sel[1:0], reg_we, retire, err}
// and compared at the falling edge against hand-computed vectors.
module tb_mc_sequencer;

  logic clk = 1'b0;
  logic rst, run, RegWr, MemWr, MemToReg, Branch, Jump, Link, br_taken;
  logic imem_ack, dmem_ack;
  logic imem_req, dmem_req, dmem_we, ir_we, pc_we, reg_we, retire, err;
  logic [1:0] pc_sel;
  logic [2:0] state;
`ifdef MC_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Flag vectors: {imr, dmr, dwe, irwe, pcwe, sel[1:0], regwe, ret, err}
  localparam logic [9:0] F_NONE  = 10'b0000000000;
  localparam logic [9:0] F_FW    = 10'b1000000000;
  localparam logic [9:0] F_FA    = 10'b1001000000;
  localparam logic [9:0] F_LD    = 10'b0100000000;
  localparam logic [9:0] F_STW   = 10'b0110000000;
  localparam logic [9:0] F_STA   = 10'b0110100010;
  localparam logic [9:0] F_WB    = 10'b0000100110;
  localparam logic [9:0] F_WBJ   = 10'b0000110110;
  localparam logic [9:0] F_BRT   = 10'b0000101010;
  localparam logic [9:0] F_PC4   = 10'b0000100010;
  localparam logic [9:0] F_JMP   = 10'b0000110010;
  localparam logic [9:0] F_ERR   = 10'b0000000001;

  always #5 clk = ~clk;

  mc_sequencer #(.ACK_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .RegWr(RegWr), .MemWr(MemWr), .MemToReg(MemToReg),
    .Branch(Branch), .Jump(Jump), .Link(Link), .br_taken(br_taken),
    .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel), .reg_we(reg_we),
    .retire(retire), .state(state), .err(err)
`ifdef MC_SEQ_PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  wire [12:0] obs_s = {state, imem_req, dmem_req, dmem_we, ir_we, pc_we,
                       pc_sel, reg_we, retire, err};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare one cycle's outputs at the falling edge, then move past the next rising edge.
  task automatic cyc(input string tag, input logic [2:0] st, input logic [9:0] fl);
    logic [12:0] exp_v;
    exp_v = {st, fl};
    @(negedge clk);
    chk(tag, {19'd0, obs_s}, {19'd0, exp_v});
    @(posedge clk);
    #1;
  endtask

  task automatic set_flags(input logic [5:0] f);
    {RegWr, MemWr, MemToReg, Branch, Jump, Link} = f;
  endtask

  // Fetch with a given number of wait cycles, then the decode cycle.
  task automatic fetch(input int waits);
    for (int i = 0; i < waits; i++) cyc("fetch_wait", 3'd1, F_FW);
    imem_ack = 1'b1;
    cyc("fetch_ack", 3'd1, F_FA);
    imem_ack = 1'b0;
    cyc("decode", 3'd2, F_NONE);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; br_taken = 1'b0;
    imem_ack = 1'b0; dmem_ack = 1'b0;
    set_flags(6'b000000);
    @(posedge clk); #1;
    cyc("reset", 3'd0, F_NONE);
    rst = 1'b0;
    cyc("idle_norun", 3'd0, F_NONE);

    // R-type, fetch acknowledged after two wait cycles.
    run = 1'b1; set_flags(6'b100000);
    cyc("rt_idle", 3'd0, F_NONE);
    fetch(2);
    cyc("rt_exec", 3'd3, F_NONE);
    run = 1'b0;
    cyc("rt_wb", 3'd5, F_WB);
    cyc("rt_park", 3'd0, F_NONE);

    // Load with immediate data ack, chained into the next instruction.
    run = 1'b1; set_flags(6'b101000);
    cyc("ld_idle", 3'd0, F_NONE);
    fetch(0);
    cyc("ld_exec", 3'd3, F_NONE);
    dmem_ack = 1'b1;
    cyc("ld_mem", 3'd4, F_LD);
    dmem_ack = 1'b0;
    cyc("ld_wb", 3'd5, F_WB);

    // Store, data ack after three wait cycles.
    set_flags(6'b010000);
    fetch(0);
    cyc("st_exec", 3'd3, F_NONE);
    for (int i = 0; i < 3; i++) cyc("st_wait", 3'd4, F_STW);
    dmem_ack = 1'b1;
    cyc("st_ack", 3'd4, F_STA);
    dmem_ack = 1'b0;

    // Branch taken / not taken, jal, plain jump, NOP, jump priority.
    set_flags(6'b000100); br_taken = 1'b1;
    fetch(0);
    cyc("br_taken", 3'd3, F_BRT);
    br_taken = 1'b0;
    fetch(0);
    cyc("br_not", 3'd3, F_PC4);
    set_flags(6'b000011);
    fetch(0);
    cyc("jal_exec", 3'd3, F_NONE);
    cyc("jal_wb", 3'd5, F_WBJ);
    set_flags(6'b000010);
    fetch(0);
    cyc("jmp_exec", 3'd3, F_JMP);
    set_flags(6'b000000);
    fetch(0);
    cyc("nop_exec", 3'd3, F_PC4);
    set_flags(6'b110110); br_taken = 1'b1;
    fetch(0);
    cyc("jmp_prio", 3'd3, F_JMP);
    br_taken = 1'b0;

    // Ack arriving exactly in the timeout cycle is accepted.
    set_flags(6'b000000);
    fetch(4);
    run = 1'b0;
    cyc("late_ack_exec", 3'd3, F_PC4);
    cyc("late_ack_idle", 3'd0, F_NONE);

    // run dropped during MEM: the load completes, then parks.
    run = 1'b1; set_flags(6'b101000);
    cyc("rd_idle", 3'd0, F_NONE);
    fetch(0);
    cyc("rd_exec", 3'd3, F_NONE);
    run = 1'b0;
    cyc("rd_mem_wait", 3'd4, F_LD);
    dmem_ack = 1'b1;
    cyc("rd_mem_ack", 3'd4, F_LD);
    dmem_ack = 1'b0;
    cyc("rd_wb", 3'd5, F_WB);
    cyc("rd_park", 3'd0, F_NONE);

    // Reset mid-MEM with an ack in the reset cycle.
    run = 1'b1;
    cyc("rm_idle", 3'd0, F_NONE);
    fetch(0);
    cyc("rm_exec", 3'd3, F_NONE);
    cyc("rm_mem", 3'd4, F_LD);
    rst = 1'b1; dmem_ack = 1'b1;
    cyc("rm_in_rst", 3'd0, F_NONE);
    rst = 1'b0; dmem_ack = 1'b0; run = 1'b0;
    cyc("rm_after", 3'd0, F_NONE);

    // Fetch watchdog: four wait cycles, timeout cycle, then sticky ERROR.
    run = 1'b1;
    cyc("to_idle", 3'd0, F_NONE);
    for (int i = 0; i < 5; i++) cyc("to_wait", 3'd1, F_FW);
    for (int i = 0; i < 20; i++) begin
      imem_ack = i[0];
      dmem_ack = ~i[0];
      cyc("to_error", 3'd7, F_ERR);
    end
    imem_ack = 1'b0; dmem_ack = 1'b0;
    rst = 1'b1; run = 1'b0;
    cyc("to_rst", 3'd0, F_NONE);
    rst = 1'b0;
    cyc("to_idle_after", 3'd0, F_NONE);

    // Three NOPs back to back.
    run = 1'b1; set_flags(6'b000000);
    cyc("cnt_idle", 3'd0, F_NONE);
    for (int i = 0; i < 3; i++) begin
      fetch(0);
      if (i == 2) run = 1'b0;
      cyc("cnt_exec", 3'd3, F_PC4);
    end
    @(negedge clk);
    chk("cnt_park", {29'd0, state}, 32'd0);
`ifdef MC_SEQ_PERF_CNT_EN
    chk("instret_cnt", instret_cnt, 32'd3);
    chk("cycle_cnt", cycle_cnt, 32'd9);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_sequencer.md
Name: mc_sequencer

Overview:
- Multi-cycle sequencer for the CPU datapath. It turns the combinational decode flags (RegWr, MemWr, MemToReg, Branch, Jump, Link) into per-cycle enables for IR, PC, register file and memory.
- It walks each instruction through IDLE/FETCH/DECODE/EXEC/MEM/WB.
- It handshakes with variable-latency instruction and data memories.
- A watchdog flags a memory that never acknowledges.

Parameters:
- ACK_TIMEOUT, 255: maximum cycles a memory request may wait for ack before ERROR (1..65535).
- CNT_W, 16: width of the internal wait counter; must hold ACK_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  1 = keep issuing instructions; 0 = park in IDLE at the next instruction boundary
- RegWr, MemWr, MemToReg, Branch, Jump, Link  in  1 each  decode flags for the instruction currently in IR
- br_taken  in  1  branch condition from the ALU, valid in EXEC
- imem_req  out  1  instruction fetch request
- imem_ack  in  1  fetch data valid this cycle
- dmem_req  out  1  data access request
- dmem_we  out  1  1 = store, 0 = load; valid while dmem_req = 1
- dmem_ack  in  1  data access complete this cycle
- ir_we  out  1  latch fetched instruction into IR
- pc_we  out  1  update PC
- pc_sel  out  2  0 = PC+4, 1 = branch target, 2 = jump target
- reg_we  out  1  register file write enable
- retire  out  1  one-cycle pulse per completed instruction
- state  out  3  IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, ERROR=7
- err  out  1  sticky watchdog error

Behaviour:
- Reset: on rst=1 at a clock edge, state goes to IDLE and the wait counter clears. All outputs are 0 during and after reset until the next transition.
- Reset wins over every other event, including a mid-request reset. An ack arriving in the reset cycle is dropped.
- Moore-style outputs decoded from state. pc_we, pc_sel, reg_we and retire also depend on the flags and on the ack inputs in the same cycle.
- IDLE:
  - All outputs 0.
  - run=1 -> FETCH.
- FETCH:
  - imem_req=1, held until imem_ack.
  - On imem_ack: ir_we=1 in the same cycle, -> DECODE.
  - run falling during FETCH does not abort the fetch.
- DECODE:
  - Single cycle; flags settle from the new IR.
  - -> EXEC.
- EXEC, single cycle, priority order:
  - Jump & Link -> WB (PC update deferred so the link value uses the old PC+4).
  - Jump & ~Link: pc_we=1, pc_sel=2, retire=1, -> next.
  - Branch: pc_we=1, pc_sel = br_taken ? 1 : 0, retire=1, -> next.
  - MemToReg | MemWr -> MEM.
  - RegWr -> WB.
  - Otherwise (NOP): pc_we=1, pc_sel=0, retire=1, -> next.
- MEM:
  - dmem_req=1, dmem_we=MemWr, held stable until dmem_ack.
  - On ack with MemToReg -> WB.
  - On ack without MemToReg (store): pc_we=1, pc_sel=0, retire=1, -> next.
- WB:
  - reg_we=1, pc_we=1, retire=1.
  - pc_sel = 2 if Jump & Link, else 0.
  - -> next.
- "next" means FETCH if run=1 in that cycle, else IDLE.
- Watchdog:
  - The counter increments each cycle in FETCH/MEM without an ack and clears on any state change.
  - When the counter equals ACK_TIMEOUT with no ack: -> ERROR, err=1, requests drop.
  - An ack in the same cycle as the timeout wins; the normal transition is taken.
- ERROR:
  - All enables 0, err=1.
  - Left only by rst.
- Invariants:
  - Acks outside FETCH/MEM are ignored.
  - imem_req and dmem_req are never both 1.
  - Exactly one retire pulse per instruction.

Optional Feature:
- Macro MC_SEQ_PERF_CNT_EN.
- Defined:
  - Adds outputs cycle_cnt[31:0], which counts every cycle not in IDLE or ERROR.
  - Adds instret_cnt[31:0], which counts retire pulses.
  - Both clear on rst and wrap from 0xFFFFFFFF to 0.
- Not defined: the ports do not exist and no counter logic is built.

Test Plan:
- R-type (RegWr=1, others 0), imem_ack after 2 wait cycles:
  - imem_req high for 3 cycles, ir_we once.
  - States 1,1,1,2,3,5; reg_we=pc_we=retire=1 in WB, pc_sel=0.
  - 6 cycles total.
- Load (MemToReg=1, RegWr=1), dmem_ack immediate:
  - Path FETCH→DECODE→EXEC→MEM→WB.
  - dmem_we=0; reg_we in WB only.
- Store (MemWr=1), dmem_ack after 3 cycles:
  - dmem_req=dmem_we=1 held for 4 cycles.
  - pc_we=retire=1 in the ack cycle; reg_we never asserted.
- Branch:
  - br_taken=1: EXEC gives pc_sel=1, pc_we=1.
  - br_taken=0: pc_sel=0.
  - jal (Jump=Link=1): WB has reg_we=1, pc_sel=2.
- ACK_TIMEOUT=4, imem_ack never asserted:
  - ERROR (state=7, err=1) after 4 wait cycles; imem_req=0.
  - Stays in ERROR through 20 cycles; rst returns to IDLE.
- Run and reset edges:
  - run dropped during MEM: instruction completes, then IDLE.
  - rst asserted mid-MEM: next cycle state=0, dmem_req=0.
  - With MC_SEQ_PERF_CNT_EN, 3 instructions give instret_cnt=3.
